// File: rtl/upload_arbiter.sv
// upload_arbiter: packet-atomic round-robin arbiter feeding the USB CDC upload
// byte stream. One source is granted at a time; its bytes are forwarded through
// a single output register with valid/ready flow control. The grant is released
// on the packet's last byte or when the granted source starves for TIMEOUT_CYC
// cycles (TIMEOUT_CYC = 0 disables the timeout).
// Optional build macro UPLOAD_ARB_HEADER_EN: prefix each packet with 0xAA and
// the granted source index.
module upload_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           upload_data,
    output logic                 upload_valid,
    input  logic                 upload_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 arb_abort
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       RR_INIT = 3'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1
`ifdef UPLOAD_ARB_HEADER_EN
        ,
        HDR0 = 2'd2,
        HDR1 = 2'd3
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       grant_reg, grant_next;
    logic [2:0]       rr_reg, rr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             abort_reg, abort_next;

    logic [NUM_SRC-1:0] grant_sel;
    logic [7:0]         data_lane [NUM_SRC];
    logic [7:0]         g_data;
    logic               g_valid;
    logic               g_last;
    logic               out_free;
    logic               beat;
    logic               pick_valid;
    logic [2:0]         pick_id;

    // One-hot decode of the granted source and split of the packed data bus
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            assign grant_sel[gi] = (grant_reg == 3'(gi));
            assign data_lane[gi] = src_data[8*gi +: 8];
        end
    endgenerate

    // Multiplex the granted source's byte onto a single lane
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_sel[i]) begin
                g_data = g_data | data_lane[i];
            end
        end
    end

    assign g_valid  = |(src_valid & grant_sel);
    assign g_last   = |(src_last & grant_sel);
    assign out_free = ~valid_reg | upload_ready;
    assign beat     = (state_reg == DATA) & out_free & g_valid;

    assign src_ready    = grant_sel & {NUM_SRC{(state_reg == DATA) & out_free}};
    assign upload_data  = data_reg;
    assign upload_valid = valid_reg;
    assign grant_id     = grant_reg;
    assign busy         = (state_reg != IDLE);
    assign arb_abort    = abort_reg;

    // Round-robin pick: first requester above rr_ptr; the loop runs from the
    // farthest candidate down so the nearest one is assigned last and wins
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            int                 idx;
            logic [NUM_SRC-1:0] req_shift;
            idx       = (int'(rr_reg) + k) % NUM_SRC;
            req_shift = src_req >> idx;
            if (req_shift[0]) begin
                pick_valid = 1'b1;
                pick_id    = 3'(idx);
            end
        end
    end

    // Next-state and datapath updates for the arbitration FSM
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        rr_next    = rr_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        abort_next = 1'b0;

        // A taken byte leaves the output register unless a new one replaces it
        if (upload_ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (pick_valid) begin
                    grant_next = pick_id;
                    rr_next    = pick_id;
`ifdef UPLOAD_ARB_HEADER_EN
                    state_next = HDR0;
`else
                    state_next = DATA;
`endif
                end
            end
`ifdef UPLOAD_ARB_HEADER_EN
            HDR0: begin
                if (out_free) begin
                    data_next  = 8'hAA;
                    valid_next = 1'b1;
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (out_free) begin
                    data_next  = {5'b0, grant_reg};
                    valid_next = 1'b1;
                    state_next = DATA;
                end
            end
`endif
            DATA: begin
                if (beat) begin
                    data_next  = g_data;
                    valid_next = 1'b1;
                    cnt_next   = '0;
                    if (g_last) begin
                        state_next = IDLE;
                    end
                end else if (!g_valid) begin
                    // Only source starvation counts; a blocked downstream does not
                    if ((TIMEOUT_CYC != 0) && (cnt_reg == CNT_LIM)) begin
                        state_next = IDLE;
                        abort_next = 1'b1;
                        cnt_next   = '0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            rr_reg    <= RR_INIT;
            cnt_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            rr_reg    <= rr_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            abort_reg <= abort_next;
        end
    end

endmodule
